// File: rtl/sample_dump_controller.sv
// ---------------------------------------------------------------------------
// sample_dump_controller
//
// Reads one channel (reference or error) of the ADC sample memory, addresses
// 0 .. size-1, and streams every 16-bit sample to the UART transmitter as two
// bytes, MSB first. One i_start pulse runs one complete dump. i_start is only
// honoured in IDLE, and the channel select and size are captured at that
// moment, so changes to them while a dump is running have no effect.
//
// Optional build macro: DUMP_HEADER_EN
//   When defined, two header bytes (0xA5, then {7'b0, select}) are sent
//   before the first sample. A size-0 dump then sends only the header.
//
// Ports:
//   i_clock        system clock
//   i_reset        synchronous active-high reset (aborts a dump, no o_done)
//   i_start        one-cycle dump request
//   i_select       channel select, 0 = reference, 1 = error (captured at start)
//   i_memory_size  number of samples to dump (captured at start)
//   o_addr         sample memory read address
//   o_mem_sel      captured channel select, drives the memory read mux
//   i_ref_data     reference memory read data, one cycle after o_addr
//   i_err_data     error memory read data, one cycle after o_addr
//   o_tx_data      byte for the UART
//   o_tx_start     one-cycle pulse, o_tx_data valid
//   i_tx_done      one-cycle pulse, UART finished the current byte
//   o_busy         dump in progress
//   o_done         one-cycle pulse at the end of a dump
//
// States:
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | waiting for i_start
//   ST_HDR0      | header byte 0 (0xA5) offered to UART   (DUMP_HEADER_EN)
//   ST_HDR0_WAIT | waiting for UART done on header byte 0 (DUMP_HEADER_EN)
//   ST_HDR1      | header byte 1 (select) offered to UART (DUMP_HEADER_EN)
//   ST_HDR1_WAIT | waiting for UART done on header byte 1 (DUMP_HEADER_EN)
//   ST_READ      | address presented to memory
//   ST_LATCH     | memory data valid, captured
//   ST_SEND_HI   | sample MSB offered to UART
//   ST_WAIT_HI   | waiting for UART done on MSB
//   ST_SEND_LO   | sample LSB offered to UART
//   ST_WAIT_LO   | waiting for UART done on LSB, then next sample or finish
//   ST_DONE      | o_done pulse, address returned to 0
// ---------------------------------------------------------------------------
module sample_dump_controller #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 12,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_select,
  input  logic [ADDR_SIZE-1:0] i_memory_size,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic                 o_mem_sel,
  input  logic [DATA_SIZE-1:0] i_ref_data,
  input  logic [DATA_SIZE-1:0] i_err_data,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [ADDR_SIZE-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
`ifdef DUMP_HEADER_EN
  localparam logic [BYTE_SIZE-1:0] HDR_MAGIC = BYTE_SIZE'(8'hA5);
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
`ifdef DUMP_HEADER_EN
    ST_HDR0,
    ST_HDR0_WAIT,
    ST_HDR1,
    ST_HDR1_WAIT,
`endif
    ST_READ,
    ST_LATCH,
    ST_SEND_HI,
    ST_WAIT_HI,
    ST_SEND_LO,
    ST_WAIT_LO,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [ADDR_SIZE-1:0]   size_q, size_d;
  logic                   sel_q, sel_d;
  logic [BYTE_SIZE-1:0]   tx_data_q, tx_data_d;
  // Only the low byte needs to be kept: the high byte goes straight into
  // tx_data when the memory word is captured.
  logic [BYTE_SIZE-1:0]   lo_byte_q, lo_byte_d;

  logic [DATA_SIZE-1:0]   mem_word;
  logic                   last_sample;

  assign mem_word    = sel_q ? i_err_data : i_ref_data;
  // Wraps naturally in ADDR_SIZE bits; size 0 never reaches this compare.
  assign last_sample = (addr_q == (size_q - ADDR_ONE));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sel_d     = sel_q;
    tx_data_d = tx_data_q;
    lo_byte_d = lo_byte_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          sel_d  = i_select;
          size_d = i_memory_size;
          addr_d = ADDR_ZERO;
`ifdef DUMP_HEADER_EN
          tx_data_d = HDR_MAGIC;
          state_d   = ST_HDR0;
`else
          state_d = (i_memory_size == ADDR_ZERO) ? ST_DONE : ST_READ;
`endif
        end
      end

`ifdef DUMP_HEADER_EN
      ST_HDR0: state_d = ST_HDR0_WAIT;

      ST_HDR0_WAIT: begin
        if (i_tx_done) begin
          tx_data_d = {{(BYTE_SIZE-1){1'b0}}, sel_q};
          state_d   = ST_HDR1;
        end
      end

      ST_HDR1: state_d = ST_HDR1_WAIT;

      ST_HDR1_WAIT: begin
        if (i_tx_done) begin
          state_d = (size_q == ADDR_ZERO) ? ST_DONE : ST_READ;
        end
      end
`endif

      ST_READ: state_d = ST_LATCH;

      ST_LATCH: begin
        tx_data_d = mem_word[DATA_SIZE-1:BYTE_SIZE];
        lo_byte_d = mem_word[BYTE_SIZE-1:0];
        state_d   = ST_SEND_HI;
      end

      // A done arriving in the same cycle as the start belongs to nothing
      // we sent, so the SEND states never look at i_tx_done.
      ST_SEND_HI: state_d = ST_WAIT_HI;

      ST_WAIT_HI: begin
        if (i_tx_done) begin
          tx_data_d = lo_byte_q;
          state_d   = ST_SEND_LO;
        end
      end

      ST_SEND_LO: state_d = ST_WAIT_LO;

      ST_WAIT_LO: begin
        if (i_tx_done) begin
          if (last_sample) begin
            addr_d  = ADDR_ZERO;
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_READ;
          end
        end
      end

      ST_DONE: begin
        addr_d  = ADDR_ZERO;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      sel_q     <= 1'b0;
      tx_data_q <= '0;
      lo_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sel_q     <= sel_d;
      tx_data_q <= tx_data_d;
      lo_byte_q <= lo_byte_d;
    end
  end

  assign o_addr    = addr_q;
  assign o_mem_sel = sel_q;
  assign o_tx_data = tx_data_q;
  assign o_done    = (state_q == ST_DONE);
  assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);

`ifdef DUMP_HEADER_EN
  assign o_tx_start = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO) ||
                      (state_q == ST_HDR0)    || (state_q == ST_HDR1);
`else
  assign o_tx_start = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO);
`endif

endmodule

// File: tb/tb_sample_dump_controller.sv
module tb_sample_dump_controller;
  localparam int DS = 16;
  localparam int AS = 12;
  localparam int BS = 8;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_select = 1'b0;
  logic [AS-1:0] i_memory_size = '0;
  logic [AS-1:0] o_addr;
  logic          o_mem_sel;
  logic [DS-1:0] ref_rd = '0;
  logic [DS-1:0] err_rd = '0;
  logic [BS-1:0] o_tx_data;
  logic          o_tx_start;
  logic          i_tx_done;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  sample_dump_controller #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .BYTE_SIZE(BS)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_select(i_select),
    .i_memory_size(i_memory_size), .o_addr(o_addr), .o_mem_sel(o_mem_sel),
    .i_ref_data(ref_rd), .i_err_data(err_rd), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_done(o_done)
  );

  int checks = 0;
  int errors = 0;

  // sample memories with one cycle read latency
  logic [DS-1:0] ref_mem [4096];
  logic [DS-1:0] err_mem [4096];
  always @(posedge clk) begin
    ref_rd <= ref_mem[o_addr];
    err_rd <= err_mem[o_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // UART model: logs every byte offered, answers after uart_delay cycles
  int   uart_delay = 5;
  int   uart_cnt = 0;
  bit   spur_on_start = 1'b0;
  logic uart_done = 1'b0;
  logic spur_done = 1'b0;
  logic [BS-1:0] got_q[$];
  int   addr_log[$];
  int   tx_cyc_log[$];
  assign i_tx_done = uart_done | spur_done;

  always @(negedge clk) begin
    uart_done = 1'b0;
    if (i_reset) begin
      uart_cnt = 0;
    end else begin
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) uart_done = 1'b1;
      end
      if (o_tx_start) begin
        got_q.push_back(o_tx_data);
        addr_log.push_back(int'(o_addr));
        tx_cyc_log.push_back(cyc);
        uart_cnt = uart_delay;
        if (spur_on_start) uart_done = 1'b1;
      end
    end
  end

  int   done_cnt = 0;
  int   sel_bad = 0;
  logic exp_sel = 1'b0;
  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_busy && (o_mem_sel !== exp_sel)) sel_bad++;
  end

`ifdef DUMP_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input int n);
    for (int i = 0; i < n; i++) begin
      ref_mem[i] = 16'($urandom);
      err_mem[i] = 16'($urandom);
    end
  endtask

  task automatic run_dump(input bit sel, input int n, input int d,
                          input bit sp_idle, input bit sp_read, input bit sp_start,
                          input bit mid);
    int gb, db, sb, start_cyc, n_wait, budget, exp_lat, ng;
    bit mid_done;
    logic busy_e1;
    logic [DS-1:0] w;
    logic [BS-1:0] exp_b[$];
    int exp_a[$];
    if (HDR) begin
      exp_b.push_back(8'hA5); exp_a.push_back(0);
      exp_b.push_back({7'b0, sel}); exp_a.push_back(0);
    end
    for (int i = 0; i < n; i++) begin
      w = sel ? err_mem[i] : ref_mem[i];
      exp_b.push_back(w[15:8]); exp_a.push_back(i);
      exp_b.push_back(w[7:0]);  exp_a.push_back(i);
    end
    exp_lat = 1 + (HDR ? 2 * (d + 1) : 0) + n * (2 * d + 4);

    uart_delay = d;
    spur_on_start = sp_start;
    exp_sel = sel;
    @(negedge clk);
    if (sp_idle) begin
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
    end
    gb = got_q.size(); db = done_cnt; sb = sel_bad;
    i_start = 1'b1; i_select = sel; i_memory_size = AS'(n); start_cyc = cyc;
    @(negedge clk);
    i_start = 1'b0;
    busy_e1 = o_busy;
    if (sp_read) spur_done = 1'b1;
    budget = 60 + n * (2 * d + 4) + 4 * d;
    n_wait = 1; mid_done = 1'b0;
    while (!o_done && n_wait < budget) begin
      @(negedge clk);
      spur_done = 1'b0; i_start = 1'b0; n_wait++;
      if (mid && !mid_done && (got_q.size() - gb) >= 3) begin
        i_start = 1'b1;
        i_memory_size = AS'($urandom_range(1, 4095));
        i_select = ~sel;
        mid_done = 1'b1;
      end
    end
    spur_done = 1'b0; i_start = 1'b0;
    check("busy_after_start", 32'(busy_e1), 32'((n > 0) || HDR));
    check("done_seen", 32'(o_done), 32'd1);
    check("done_latency", 32'(cyc - start_cyc), 32'(exp_lat));
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("addr_at_done", 32'(o_addr), 32'd0);
    @(negedge clk);
    check("done_single_pulse", 32'(o_done), 32'd0);
    check("busy_after_done", 32'(o_busy), 32'd0);
    check("done_count", 32'(done_cnt - db), 32'd1);
    check("mem_sel_held", 32'(sel_bad - sb), 32'd0);
    ng = got_q.size() - gb;
    check("byte_count", 32'(ng), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < ng; i++) begin
      check("tx_byte", 32'(got_q[gb + i]), 32'(exp_b[i]));
      check("tx_addr", 32'(addr_log[gb + i]), 32'(exp_a[i]));
    end
    if (ng > 0) check("first_tx_latency", 32'(tx_cyc_log[gb] - start_cyc), HDR ? 32'd1 : 32'd3);
  endtask

  initial begin
    int gb, db, k, n;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_sel", 32'(o_mem_sel), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    // directed: reference channel, three samples, spurious done in idle
    ref_mem[0] = 16'h1234; ref_mem[1] = 16'hABCD; ref_mem[2] = 16'h00FF;
    run_dump(1'b0, 3, 5, 1'b1, 1'b0, 1'b0, 1'b0);

    // directed: error channel, one sample, spurious done in READ
    err_mem[0] = 16'hBEEF;
    run_dump(1'b1, 1, 5, 1'b0, 1'b1, 1'b0, 1'b0);

    // size zero
    run_dump(1'b1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_dump(1'b0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // restart and size/select changes mid-dump
    fill_mem(5);
    run_dump(1'b1, 5, 2, 1'b0, 1'b0, 1'b0, 1'b1);

    // spurious done coinciding with every tx start
    fill_mem(4);
    run_dump(1'b0, 4, 3, 1'b1, 1'b1, 1'b1, 1'b0);

    // reset while waiting on the LSB handshake
    fill_mem(3);
    uart_delay = 4; spur_on_start = 1'b0; exp_sel = 1'b1;
    @(negedge clk);
    gb = got_q.size(); db = done_cnt;
    i_start = 1'b1; i_select = 1'b1; i_memory_size = AS'(3);
    @(negedge clk);
    i_start = 1'b0;
    k = 0;
    while ((got_q.size() - gb) < 4 && k < 200) begin
      @(negedge clk); k++;
    end
    check("reach_wait_lo", 32'(k < 200), 32'd1);
    if (o_tx_start) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("abort_addr", 32'(o_addr), 32'd0);
    check("abort_sel", 32'(o_mem_sel), 32'd0);
    check("abort_tx_data", 32'(o_tx_data), 32'd0);
    check("abort_tx_start", 32'(o_tx_start), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - db), 32'd0);
    check("abort_no_more_bytes", 32'(got_q.size() - gb), 32'd4);
    check("abort_idle", 32'(o_busy), 32'd0);
    fill_mem(3);
    run_dump(1'b1, 3, 4, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized dumps
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 9);
      fill_mem(n);
      run_dump(1'($urandom_range(0, 1)), n, $urandom_range(1, 6),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), (n >= 3) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // largest expressible dump
    fill_mem(4095);
    run_dump(1'b1, 4095, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
